// File: rtl/counter_ctrl_if.sv
// Bundle of the control, status and configuration signals for counter_ctrl.
// start/stop/ack are single-cycle command pulses sampled on posedge clk,
// pause is a level; there is no valid/ready back-pressure on any of them: a
// pulse that the FSM cannot use in its current state is simply dropped.
interface counter_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             pause;
    logic [WIDTH-1:0] tc_in;
    logic             auto_reload;
    logic             ack;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             overrun;
    logic [1:0]       state;

    // Driver side (bench or host controller)
    modport master (
        output start, stop, pause, tc_in, auto_reload, ack,
        input  q, busy, done, overrun, state
    );

    // Counter side
    modport slave (
        input  start, stop, pause, tc_in, auto_reload, ack,
        output q, busy, done, overrun, state
    );
endinterface

// File: rtl/counter_ctrl.sv
// Run/pause/stop counter with a programmable terminal count, one-shot or
// periodic (auto-reload) mode, a done flag cleared by ack and a sticky overrun
// flag for terminal events that arrive while done is still pending.
module counter_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    counter_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] tc_q, tc_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;

    // Next-state and register-update logic for the whole controller
    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        tc_d      = tc_q;
        mode_d    = mode_q;
        done_d    = done_q;
        overrun_d = overrun_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    tc_d      = bus.tc_in;
                    mode_d    = bus.auto_reload;
                    q_d       = '0;
                    overrun_d = 1'b0;
                    // A zero terminal count is a terminal event on the start edge
                    if (bus.tc_in == '0) begin
                        done_d  = 1'b1;
                        state_d = bus.auto_reload ? S_RUN : S_DONE;
                    end else begin
                        done_d  = 1'b0;
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                    q_d     = '0;
                    done_d  = 1'b0;
                end else begin
                    done_d = done_q & ~bus.ack;
                    if (bus.pause) begin
                        state_d = S_PAUSE;
                    end else if (q_q == tc_q) begin
                        // Terminal event: set wins over a coincident ack, and
                        // only an un-acked pending done counts as an overrun
                        if (done_q && !bus.ack) begin
                            overrun_d = 1'b1;
                        end
                        done_d = 1'b1;
                        if (mode_q) begin
                            q_d = '0;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        q_d = q_q + 1'b1;
                    end
                end
            end

            S_PAUSE: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                    q_d     = '0;
                    done_d  = 1'b0;
                end else begin
                    done_d = done_q & ~bus.ack;
                    if (!bus.pause) begin
                        state_d = S_RUN;
                    end
                end
            end

            S_DONE: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                    q_d     = '0;
                    done_d  = 1'b0;
                end else if (bus.ack) begin
                    if (bus.start) begin
                        tc_d      = bus.tc_in;
                        mode_d    = bus.auto_reload;
                        q_d       = '0;
                        overrun_d = 1'b0;
                        if (bus.tc_in == '0) begin
                            done_d  = 1'b1;
                            state_d = bus.auto_reload ? S_RUN : S_DONE;
                        end else begin
                            done_d  = 1'b0;
                            state_d = S_RUN;
                        end
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b0;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            q_q       <= '0;
            tc_q      <= '0;
            mode_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            tc_q      <= tc_d;
            mode_q    <= mode_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.q       = q_q;
    assign bus.done    = done_q;
    assign bus.overrun = overrun_q;
    assign bus.state   = state_q;
    assign bus.busy    = (state_q == S_RUN) || (state_q == S_PAUSE);

endmodule
